data_sram_slave: RTL and testbench

AXI4-Lite-style memory slave that answers the write-back stage's data-memory master port (AR/R for loads, AW/W/B for stores). It holds a word-addressed SRAM array and applies byte strobes on writes. Each channel inserts a configurable or pseudo-random response delay so that stall paths upstream get exercised. It sits directly downstream of the write-back stage and is the only sink of its `mem_*` signals.

---
 rtl/data_sram_slave_pkg.sv | 30 +++
 rtl/data_sram_slave_lat_counter.sv | 37 +++
 rtl/data_sram_slave.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_data_sram_slave.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// dsram_pkg
// Shared definitions for the data-memory slave: response codes, channel FSM
// state encodings, the LFSR seed and the LFSR step function used to produce
// pseudo-random response latencies.
// -----------------------------------------------------------------------------
package dsram_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_DELAY = 2'b01,
        R_RESP  = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'b00,
        W_DELAY = 2'b01,
        W_RESP  = 2'b10
    } wr_state_e;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/data_sram_slave_lat_counter.sv
// -----------------------------------------------------------------------------
// lat_counter
// Loadable 4-bit down-counter. Counts toward zero one step per cycle and stops
// there; done is high whenever the count is zero.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   load     in   load load_val this cycle
//   load_val in   4-bit value to load
//   done     out  count has reached zero
// -----------------------------------------------------------------------------
module lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] count_r;

    // Down-counter register: load has priority, otherwise saturate at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == 4'd0);

endmodule

// File: rtl/data_sram_slave.sv
// -----------------------------------------------------------------------------
// data_sram_slave
// AXI4-Lite-style word-addressed SRAM slave for the write-back stage's data
// port. Independent read (AR/R) and write (AW/W/B) FSMs, one outstanding
// transaction each, with a fixed or LFSR-driven response delay per channel.
// Ports:
//   clk, rst                     clock / asynchronous active-low reset
//   arvalid, arready, araddr     read address channel
//   rvalid, rready, rdata, rresp read data channel
//   awvalid, awready, awaddr     write address channel
//   wvalid, wready, wdata, wstrb write data channel (wstrb[3:0] used)
//   bvalid, bready, bresp        write response channel
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module data_sram_slave
    import dsram_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          READ_LAT  = 1,
    parameter int          WRITE_LAT = 1,
    parameter int          RAND_LAT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

    // 33-bit compare so a window ending at the top of the address map still works.
    function automatic logic addr_hit(input logic [31:0] addr);
        return (addr >= BASE) && ({1'b0, addr} < ADDR_LIMIT);
    endfunction

    logic [31:0] mem [DEPTH];
    logic [15:0] lfsr_r;

    // ---------------- read channel signals ----------------
    rd_state_e        rd_state_r, rd_next_s;
    logic [IDX_W-1:0] rd_idx_r;
    logic             rd_hit_r;
    logic             ar_hs_s, r_hs_s, rd_fire_s, rd_done_s;
    logic [3:0]       rd_lat_s;
    logic [31:0]      rd_off_s;
    logic             arready_r, rvalid_r;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;

    // ---------------- write channel signals ----------------
    wr_state_e        wr_state_r, wr_next_s;
    logic [IDX_W-1:0] wr_idx_r;
    logic             wr_hit_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wstrb_r;
    logic             aw_held_r, w_held_r, aw_held_next_s, w_held_next_s;
    logic             aw_hs_s, w_hs_s, b_hs_s, wr_load_s, wr_commit_s, wr_done_s;
    logic [3:0]       wr_lat_s;
    logic [31:0]      wr_off_s;
    logic             awready_r, wready_r, bvalid_r;
    logic [1:0]       bresp_r;

    assign rd_off_s = araddr - BASE;
    assign wr_off_s = awaddr - BASE;
    assign rd_lat_s = (RAND_LAT != 32'sd0) ? lfsr_r[3:0] : 4'(READ_LAT);
    assign wr_lat_s = (RAND_LAT != 32'sd0) ? lfsr_r[3:0] : 4'(WRITE_LAT);

    // Byte-address bits below the word and above the array are don't-care.
    logic unused_ok_s;
    assign unused_ok_s = ^{wstrb[7:4], rd_off_s[1:0], rd_off_s[31:IDX_W+2],
                           wr_off_s[1:0], wr_off_s[31:IDX_W+2]};

    // Shared LFSR, free-running every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    lat_counter u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ar_hs_s),
        .load_val (rd_lat_s),
        .done     (rd_done_s)
    );

    lat_counter u_wr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load_s),
        .load_val (wr_lat_s),
        .done     (wr_done_s)
    );

    // Read FSM next-state and handshake decode.
    always_comb begin
        rd_next_s = rd_state_r;
        ar_hs_s   = 1'b0;
        r_hs_s    = 1'b0;
        rd_fire_s = 1'b0;
        case (rd_state_r)
            R_IDLE: begin
                if (arvalid && arready_r) begin
                    ar_hs_s   = 1'b1;
                    rd_next_s = R_DELAY;
                end else begin
                    rd_next_s = R_IDLE;
                end
            end
            R_DELAY: begin
                if (rd_done_s) begin
                    rd_fire_s = 1'b1;
                    rd_next_s = R_RESP;
                end else begin
                    rd_next_s = R_DELAY;
                end
            end
            R_RESP: begin
                if (rvalid_r && rready) begin
                    r_hs_s    = 1'b1;
                    rd_next_s = R_IDLE;
                end else begin
                    rd_next_s = R_RESP;
                end
            end
            default: begin
                rd_next_s = R_IDLE;
            end
        endcase
    end

    // Read state, latched request and registered R outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_r <= R_IDLE;
            rd_idx_r   <= '0;
            rd_hit_r   <= 1'b0;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            rresp_r    <= RESP_OKAY;
        end else begin
            rd_state_r <= rd_next_s;
            arready_r  <= (rd_next_s == R_IDLE);
            if (ar_hs_s) begin
                rd_idx_r <= rd_off_s[IDX_W+1:2];
                rd_hit_r <= addr_hit(araddr);
            end
            // Sampled on the same edge as a possible commit, so a colliding
            // write is not yet visible here.
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_hit_r ? mem[rd_idx_r] : 32'd0;
                rresp_r  <= rd_hit_r ? RESP_OKAY : RESP_DECERR;
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Write FSM next-state, AW/W capture bookkeeping and commit decode.
    always_comb begin
        wr_next_s      = wr_state_r;
        aw_hs_s        = 1'b0;
        w_hs_s         = 1'b0;
        b_hs_s         = 1'b0;
        wr_load_s      = 1'b0;
        wr_commit_s    = 1'b0;
        aw_held_next_s = aw_held_r;
        w_held_next_s  = w_held_r;
        case (wr_state_r)
            W_IDLE: begin
                aw_hs_s = awvalid && awready_r;
                w_hs_s  = wvalid && wready_r;
                if ((aw_held_r || aw_hs_s) && (w_held_r || w_hs_s)) begin
                    wr_load_s      = 1'b1;
                    wr_next_s      = W_DELAY;
                    aw_held_next_s = 1'b0;
                    w_held_next_s  = 1'b0;
                end else begin
                    wr_next_s      = W_IDLE;
                    aw_held_next_s = aw_held_r || aw_hs_s;
                    w_held_next_s  = w_held_r || w_hs_s;
                end
            end
            W_DELAY: begin
                if (wr_done_s) begin
                    wr_commit_s = 1'b1;
                    wr_next_s   = W_RESP;
                end else begin
                    wr_next_s = W_DELAY;
                end
            end
            W_RESP: begin
                if (bvalid_r && bready) begin
                    b_hs_s    = 1'b1;
                    wr_next_s = W_IDLE;
                end else begin
                    wr_next_s = W_RESP;
                end
            end
            default: begin
                wr_next_s      = W_IDLE;
                aw_held_next_s = 1'b0;
                w_held_next_s  = 1'b0;
            end
        endcase
    end

    // Write state, captured AW/W payload and registered B/ready outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_r <= W_IDLE;
            wr_idx_r   <= '0;
            wr_hit_r   <= 1'b0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            wr_state_r <= wr_next_s;
            aw_held_r  <= aw_held_next_s;
            w_held_r   <= w_held_next_s;
            // Each side re-arms only once the FSM is idle and that side is free.
            awready_r  <= (wr_next_s == W_IDLE) && !aw_held_next_s;
            wready_r   <= (wr_next_s == W_IDLE) && !w_held_next_s;
            if (aw_hs_s) begin
                wr_idx_r <= wr_off_s[IDX_W+1:2];
                wr_hit_r <= addr_hit(awaddr);
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb[3:0];
            end
            if (wr_commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_hit_r ? RESP_OKAY : RESP_DECERR;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // SRAM array: byte-lane writes, not reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s && wr_hit_r) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_r[i]) begin
                    mem[wr_idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;

endmodule

// File: tb/tb_data_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_data_sram_slave
// Self-checking bench for data_sram_slave: directed scenarios followed by
// randomized loads/stores, checked against an associative-array memory model
// with handshake-relative latency expectations.
// -----------------------------------------------------------------------------
module tb_data_sram_slave;

    localparam int          DEPTH     = 4096;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          READ_LAT  = 1;
    localparam int          WRITE_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = 32'd0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = 32'd0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = 32'd0;
    logic [7:0]  wstrb = 8'd0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];
    logic [31:0] win_addr [10];
    logic [31:0] oor_addr [4];

    data_sram_slave #(
        .DEPTH(DEPTH), .BASE(BASE), .READ_LAT(READ_LAT),
        .WRITE_LAT(WRITE_LAT), .RAND_LAT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tb_hit(input logic [31:0] a);
        logic [63:0] lo, hi, x;
        lo = {32'd0, BASE};
        hi = lo + 64'(DEPTH) * 64'd4;
        x  = {32'd0, a};
        return (x >= lo) && (x < hi);
    endfunction

    function automatic int tb_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int aw_start,
                            input int w_start, input int bhold);
        int aw_cyc = -1, w_cyc = -1, b_cyc = -1, last;
        int aw_bad = 0, w_bad = 0, b_bad = 0;
        logic [31:0] tmp;
        int idx;
        for (int c = 0; c < 60; c++) begin
            if (bvalid) begin
                b_cyc = c;
                break;
            end
            if (aw_cyc >= 0 && awready) aw_bad++;
            if (w_cyc >= 0 && wready) w_bad++;
            if (c >= aw_start) begin awvalid = 1'b1; awaddr = addr; end
            if (c >= w_start) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            if (awvalid && awready && aw_cyc < 0) aw_cyc = c;
            if (wvalid && wready && w_cyc < 0) w_cyc = c;
            @(posedge clk); #1;
        end
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        check_eq("wr_lat", 32'(b_cyc), 32'(last + 2 + WRITE_LAT));
        check_eq("aw_ready_low", 32'(aw_bad), 32'd0);
        check_eq("w_ready_low", 32'(w_bad), 32'd0);
        if (b_cyc >= 0) begin
            check_eq("bresp", {30'd0, bresp}, tb_hit(addr) ? 32'd0 : 32'd3);
            for (int h = 0; h < bhold; h++) begin
                @(posedge clk); #1;
                if (!bvalid) b_bad++;
            end
            check_eq("b_hold", 32'(b_bad), 32'd0);
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
            awvalid = 1'b0;
            wvalid = 1'b0;
            check_eq("b_done", {29'd0, bvalid, awready, wready}, 32'd3);
            if (tb_hit(addr)) begin
                idx = tb_idx(addr);
                tmp = model.exists(idx) ? model[idx] : 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) tmp[8*i +: 8] = data[8*i +: 8];
                end
                model[idx] = tmp;
            end
        end else begin
            awvalid = 1'b0;
            wvalid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        logic [31:0] d0;
        logic [1:0]  r0;
        int ar_cyc = -1, r_cyc = -1, unstable = 0;
        if (tb_hit(addr)) begin
            exp_d = model[tb_idx(addr)];
            exp_r = 2'b00;
        end else begin
            exp_d = 32'd0;
            exp_r = 2'b11;
        end
        arvalid = 1'b1;
        araddr  = addr;
        for (int c = 0; c < 40; c++) begin
            if (rvalid) begin
                r_cyc = c;
                break;
            end
            if (ar_cyc < 0 && arvalid && arready) ar_cyc = c;
            @(posedge clk); #1;
            if (ar_cyc == c) begin
                arvalid = 1'b0;
                check_eq("ar_drop", {31'd0, arready}, 32'd0);
            end
        end
        arvalid = 1'b0;
        check_eq("rd_lat", 32'(r_cyc), 32'(ar_cyc + 2 + READ_LAT));
        if (r_cyc >= 0) begin
            check_eq("rdata", rdata, exp_d);
            check_eq("rresp", {30'd0, rresp}, {30'd0, exp_r});
            d0 = rdata;
            r0 = rresp;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!rvalid || rdata !== d0 || rresp !== r0 || arready) unstable++;
            end
            check_eq("r_stable", 32'(unstable), 32'd0);
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
            check_eq("r_done", {30'd0, rvalid, arready}, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        win_addr[0] = BASE + 32'h10;           // word 4
        win_addr[1] = BASE;                    // word 0
        win_addr[2] = BASE + 32'h14;
        win_addr[3] = BASE + 32'h18;
        win_addr[4] = BASE + 32'h1C;
        win_addr[5] = BASE + 32'h20;
        win_addr[6] = BASE + 32'h24;
        win_addr[7] = BASE + 32'h28;
        win_addr[8] = BASE + 32'h2C;
        win_addr[9] = BASE + 32'(DEPTH) * 32'd4 - 32'd4;
        oor_addr[0] = 32'h7FFF_FFFC;
        oor_addr[1] = BASE + 32'(DEPTH) * 32'd4;
        oor_addr[2] = 32'h0000_1000;
        oor_addr[3] = 32'hFFFF_FFFC;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {29'd0, arready, awready, wready}, 32'd7);
        check_eq("rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Store DEADBEEF at 0x8000_0010 and initialise the rest of the window.
        do_write(win_addr[0], 32'hDEAD_BEEF, 8'h0F, 0, 0, 0);
        for (int k = 1; k < 10; k++) do_write(win_addr[k], $urandom, 8'h0F, 0, 0, 0);
        do_read(win_addr[0], 0);

        // Single-byte store into the same word.
        do_write(win_addr[0], 32'h00AB_0000, 8'h04, 0, 0, 1);
        do_read(win_addr[0], 0);
        check_eq("byte_merge", model[4], 32'hDEAB_BEEF);

        // AW three cycles ahead of W, and W ahead of AW.
        do_write(win_addr[2], 32'h1234_5678, 8'h0F, 0, 3, 0);
        do_read(win_addr[2], 0);
        do_write(win_addr[3], 32'hCAFE_F00D, 8'h03, 2, 0, 2);
        do_read(win_addr[3] + 32'd3, 0);

        // Out-of-range read and write; word 0 and the last word stay intact.
        do_read(32'h7FFF_FFFC, 0);
        do_write(BASE + 32'(DEPTH) * 32'd4, 32'h5555_AAAA, 8'h0F, 0, 0, 0);
        do_read(win_addr[1], 0);
        do_read(win_addr[9], 0);

        // Hold rready low for five cycles.
        do_read(win_addr[0], 5);

        // Empty strobe and upper-only strobe change nothing.
        do_write(win_addr[4], 32'hFFFF_FFFF, 8'h00, 0, 0, 0);
        do_write(win_addr[4], 32'hFFFF_FFFF, 8'hF0, 1, 0, 0);
        do_read(win_addr[4], 0);

        // Commit and read sample on the same edge: read sees the old value.
        fork
            do_write(win_addr[5], 32'h0BAD_CAFE, 8'h0F, 0, 0, 0);
            do_read(win_addr[5], 0);
        join
        do_read(win_addr[5], 0);

        // Reset during W_DELAY aborts the store.
        awvalid = 1'b1; awaddr = win_addr[6];
        wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 8'h0F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ready", {29'd0, arready, awready, wready}, 32'd7);
        check_eq("mid_rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'd0);
        check_eq("mid_rst_resp", {28'd0, rresp, bresp}, 32'd0);
        awvalid = 1'b0;
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_read(win_addr[6], 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = oor_addr[$urandom_range(0, 3)];
            else a = win_addr[$urandom_range(0, 9)] + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
